// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MIPS opcodes, instruction field positions and the
// fetch-stage FSM state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {
    REQ       = 2'd0,
    HOLD      = 2'd1,
    WAIT_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential PC+4 or a word-aligned branch target.
module pc_next_logic #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  assign pc_plus4_o = pc_i + ADDR_W'(4);
  assign pc_next_o  = branch_taken_i ? {branch_target_i[ADDR_W-1:2], 2'b00} : pc_plus4_o;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack fetch, instruction register and
// MIPS field split. Optional fetch timeout is enabled by FETCH_TIMEOUT_EN.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              kill_q, kill_d;
  logic              req_en_q;
  logic [ADDR_W-1:0] pc_branch, pc_seq;
  logic              ack_v;
  logic              redirect;

  // req_en_q keeps imem_req low through reset and raises it on the first edge after release.
  assign imem_req  = req_en_q && (state_q != HOLD);
  assign imem_addr = kill_q ? hold_addr_q : pc_q;
  assign ack_v     = imem_req && imem_ack;
  assign redirect  = branch_taken && valid_q;

  pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc_i           (pc_q),
    .branch_taken_i (redirect),
    .branch_target_i(branch_target),
    .pc_next_o      (pc_branch),
    .pc_plus4_o     (pc_seq)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    hold_addr_d = hold_addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    kill_d      = kill_q;

    case (state_q)
      REQ: begin
        if (redirect) begin
          pc_d    = pc_branch;
          valid_d = 1'b0;
          if (!ack_v) begin
            // Outstanding request must keep its address until acked; its data is then dropped.
            kill_d      = 1'b1;
            hold_addr_d = pc_q;
            state_d     = WAIT_DROP;
          end
        end else if (ack_v) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_seq;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = pc_branch;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (!stall) begin
          state_d = REQ;
        end
      end
      WAIT_DROP: begin
        if (ack_v) begin
          kill_d  = 1'b0;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      pc_out_q    <= RESET_PC;
      hold_addr_q <= RESET_PC;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      kill_q      <= 1'b0;
      req_en_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_out_q    <= pc_out_d;
      hold_addr_q <= hold_addr_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      kill_q      <= kill_d;
      req_en_q    <= 1'b1;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign rs          = instr_q[RS_MSB:RS_LSB];
  assign rt          = instr_q[RT_MSB:RT_LSB];
  assign rd          = instr_q[RD_MSB:RD_LSB];
  assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign imm         = instr_q[IMM_MSB:IMM_LSB];
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + ADDR_W'(4);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fetch_err_q, fetch_err_d;

  // Counts edges spent requesting without an ack; saturates at TIMEOUT.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
    if (ack_v) begin
      wait_cnt_d = '0;
    end else if (imem_req && (wait_cnt_q != CNT_W'(TIMEOUT))) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (wait_cnt_d == CNT_W'(TIMEOUT)) fetch_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_instr_fetch_stage;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              stall = 1'b0;
  logic              branch_taken = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [5:0]        op;
  logic [4:0]        rs, rt, rd;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] pc_out, pc_plus4;
  logic              fetch_err;

  always #5 clk = ~clk;

  instr_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .imm(imm), .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what the bus and the IR must show.
  bit          m_started, m_req, m_valid, m_dead, m_err;
  logic [31:0] m_pc, m_addr, m_instr, m_pc_out;
  int          m_wait;

  task automatic model_reset();
    m_started = 0; m_req = 0; m_valid = 0; m_dead = 0; m_err = 0;
    m_pc = 0; m_addr = 0; m_instr = 0; m_pc_out = 0; m_wait = 0;
  endtask

  task automatic model_step(input bit ack, input logic [31:0] rdata, input bit stl,
                            input bit br, input logic [31:0] tgt);
    bit ack_seen, redirect;
    ack_seen = ack && m_req;
    redirect = br && m_valid;
`ifdef FETCH_TIMEOUT_EN
    if (ack_seen) m_wait = 0;
    else if (m_req && m_wait < TIMEOUT) begin
      m_wait++;
      if (m_wait == TIMEOUT) m_err = 1;
    end
`endif
    if (!m_req) begin
      if (!m_started) begin
        m_started = 1; m_req = 1; m_addr = m_pc;
      end else if (redirect) begin
        m_pc = tgt & 32'hFFFF_FFFC; m_valid = 0; m_req = 1; m_addr = m_pc;
      end else if (!stl) begin
        m_req = 1; m_addr = m_pc;
      end
    end else if (m_dead) begin
      if (ack_seen) begin m_dead = 0; m_addr = m_pc; end
    end else if (redirect) begin
      m_pc = tgt & 32'hFFFF_FFFC; m_valid = 0;
      if (ack_seen) m_addr = m_pc;
      else m_dead = 1;
    end else if (ack_seen) begin
      m_instr = rdata; m_pc_out = m_addr; m_valid = 1; m_pc = m_addr + 32'd4; m_req = 0;
    end
  endtask

  always @(negedge clk) begin
    check("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check("imem_addr", imem_addr, m_addr);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instr", instr, m_instr);
    check("pc_out", pc_out, m_pc_out);
    check("pc_plus4", pc_plus4, m_pc_out + 32'd4);
    check("op", 32'(op), m_instr >> 26);
    check("rs", 32'(rs), (m_instr >> 21) & 32'h1F);
    check("rt", 32'(rt), (m_instr >> 16) & 32'h1F);
    check("rd", 32'(rd), (m_instr >> 11) & 32'h1F);
    check("funct", 32'(funct), m_instr & 32'h3F);
    check("imm", 32'(imm), m_instr & 32'hFFFF);
    check("fetch_err", 32'(fetch_err), 32'(m_err));
  end

  task automatic tick(input bit ack, input logic [31:0] rdata, input bit stl,
                      input bit br, input logic [31:0] tgt);
    imem_ack = ack; imem_rdata = rdata; stall = stl; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    model_step(ack, rdata, stl, br, tgt);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; imem_ack = 0; imem_rdata = 0; stall = 0; branch_taken = 0; branch_target = 0;
    model_reset();
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  logic [31:0] seq_words [4] = '{32'h0000_0000, 32'h0043_0820, 32'hAC22_0008, 32'h1022_FFFF};
  logic [5:0]  seq_ops   [4] = '{6'b000000, 6'b000000, 6'b101011, 6'b000100};

  initial begin
    int          resp_cnt;
    bit          ack;
    bit          did_rst;
    logic [31:0] rdata;

    // Reset release and first fetch.
    do_reset();
    tick(0, 0, 0, 0, 0);
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    tick(1, 32'h8C22_0004, 0, 0, 0);
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_op", 32'(op), 32'h23);
    check("t1_rs", 32'(rs), 32'd1);
    check("t1_rt", 32'(rt), 32'd2);
    check("t1_imm", 32'(imm), 32'h4);
    check("t1_pc_out", pc_out, 32'h0);
    tick(0, 0, 0, 0, 0);
    check("t1_next_addr", imem_addr, 32'h4);

    // Sequential fetch stream.
    do_reset();
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, seq_words[i], 0, 0, 0);
      check("t2_op", 32'(op), 32'(seq_ops[i]));
      check("t2_pc_out", pc_out, 32'(i * 4));
      if (i == 1) begin
        check("t2_rd", 32'(rd), 32'd1);
        check("t2_funct", 32'(funct), 32'h20);
      end
      tick(0, 0, 0, 0, 0);
    end

    // Stall in HOLD.
    tick(1, 32'h2108_0001, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 0, 0);
      check("t3_req", 32'(imem_req), 32'd0);
      check("t3_instr", instr, 32'h2108_0001);
      check("t3_pc_out", pc_out, 32'h10);
    end
    tick(0, 0, 0, 0, 0);
    check("t3_resume", imem_addr, 32'h14);

    // Branch in HOLD.
    tick(1, 32'h0000_0020, 0, 0, 0);
    tick(0, 0, 0, 1, 32'h0000_0043);
    check("t4_valid", 32'(instr_valid), 32'd0);
    check("t4_addr", imem_addr, 32'h40);

    // Redirect while a fetch is outstanding.
    tick(1, 32'h8C01_0000, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t5_req_addr", imem_addr, 32'h44);
    tick(0, 0, 0, 1, 32'h100);
    check("t5_flush", 32'(instr_valid), 32'd0);
    check("t5_hold_addr", imem_addr, 32'h44);
    tick(0, 0, 0, 1, 32'h200);
    check("t5_ignored_br", imem_addr, 32'h44);
    tick(0, 0, 0, 0, 0);
    tick(1, 32'hDEAD_BEEF, 0, 0, 0);
    check("t5_new_addr", imem_addr, 32'h100);
    check("t5_dropped", 32'(instr_valid), 32'd0);
    check("t5_instr_kept", instr, 32'h8C01_0000);
    tick(1, 32'h1234_5678, 0, 0, 0);
    check("t5_pc_out", pc_out, 32'h100);
    check("t5_instr", instr, 32'h1234_5678);

    // Stall plus branch, then PC wrap.
    tick(0, 0, 1, 1, 32'hFFFF_FFFF);
    check("tw_flush", 32'(instr_valid), 32'd0);
    check("tw_addr", imem_addr, 32'hFFFF_FFFC);
    tick(1, 32'hAC00_0000, 0, 0, 0);
    check("tw_pc_out", pc_out, 32'hFFFF_FFFC);
    check("tw_pc_plus4", pc_plus4, 32'h0);
    tick(0, 0, 0, 0, 0);
    check("tw_next_addr", imem_addr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    do_reset();
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick(0, 0, 0, 0, 0);
    check("t6_err_before", 32'(fetch_err), 32'd0);
    tick(0, 0, 0, 0, 0);
    check("t6_err_set", 32'(fetch_err), 32'd1);
    tick(1, 32'h0000_0001, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t6_err_sticky", 32'(fetch_err), 32'd1);
`endif

    // Randomized traffic with one reset in the middle of a fetch.
    do_reset();
    resp_cnt = $urandom_range(0, 3);
    did_rst  = 0;
    for (int n = 0; n < 3000; n++) begin
      ack   = 0;
      rdata = $urandom;
      if (!did_rst && n >= 1500 && imem_req) begin
        do_reset();
        did_rst  = 1;
        resp_cnt = $urandom_range(0, 3);
      end
      if (imem_req) begin
        if (resp_cnt == 0) begin
          ack      = 1;
          resp_cnt = $urandom_range(0, 3);
        end else begin
          resp_cnt--;
        end
      end
      tick(ack, rdata, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), $urandom);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the main control decoder. It holds the PC and issues word fetches to instruction memory over a req/ack handshake. It latches the returned word into an instruction register and splits the MIPS fields, so op[5:0] drives the main control decoder and the other fields feed the register file and the ALU control. It supports stalls and branch redirects, including redirect while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
ADDR_W, 32, PC and memory address width
TIMEOUT, 16, max wait cycles for imem_ack (used only with the optional feature)

Ports:
clk  in  1  clock; rising edge active
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  ADDR_W  word address; stable while imem_req is high
imem_ack  in  1  one-cycle response strobe; imem_rdata is valid in that cycle
imem_rdata  in  32  fetched instruction word
stall  in  1  downstream hold; freezes the IR and PC
branch_taken  in  1  redirect pulse; honoured only while instr_valid=1
branch_target  in  ADDR_W  redirect address; bits [1:0] ignored, forced to 00
instr_valid  out  1  IR holds a live instruction
instr  out  32  instruction register
op  out  6  instr[31:26], to the main control decoder
rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
funct  out  6  instr[5:0]
imm  out  16  instr[15:0]
pc_out  out  ADDR_W  address of the instruction currently in the IR
pc_plus4  out  ADDR_W  pc_out+4, wraps modulo 2^ADDR_W
fetch_err  out  1  sticky timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (async, rst_n=0):
  - State REQ; PC=RESET_PC.
  - imem_req=0 while rst_n=0. After release, imem_req=1 on the first rising edge.
  - instr_valid=0, instr=0, pc_out=RESET_PC, kill=0, fetch_err=0.
- FSM states are REQ, HOLD and WAIT_DROP.
- REQ:
  - imem_req=1 and imem_addr=PC.
  - On imem_ack: instr<=imem_rdata, pc_out<=PC, instr_valid<=1, PC<=PC+4, go to HOLD.
  - Latency is one cycle from imem_ack to instr_valid.
- HOLD, stall=1: IR, pc_out and PC are frozen. imem_req=0.
- HOLD, stall=0, branch_taken=0: go to REQ next cycle. instr_valid stays 1 until the next ack replaces the IR.
  - Downstream consumes an instruction when instr_valid=1 and stall=0.
  - Throughput is therefore at most one instruction per two cycles.
- branch_taken=1 with instr_valid=1:
  - PC<=branch_target & ~3 and instr_valid<=0 (flush) on the same edge.
  - If the state is REQ with no ack that cycle: set kill and go to WAIT_DROP.
  - If the state is REQ and ack arrives the same cycle: discard the data and go to REQ with the new PC.
  - If the state is HOLD: go to REQ.
- WAIT_DROP:
  - imem_req stays 1 and imem_addr keeps the old address (protocol requires stability).
  - On imem_ack the data is dropped, kill is cleared, and the state goes to REQ with the new PC on the next cycle.
  - A further branch_taken is ignored because instr_valid=0.
- Simultaneous stall and branch_taken: the branch wins and the IR is flushed.
- branch_taken while instr_valid=0: ignored.
- PC arithmetic is unsigned modulo 2^ADDR_W; 32'hFFFF_FFFC+4 gives 0.
- rst_n asserted mid-fetch: everything returns to its reset value immediately. The imem side must tolerate the req drop.
- Field outputs are pure wiring from instr.

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined: a wait counter of width $clog2(TIMEOUT+1) runs in REQ and WAIT_DROP and clears on ack.
  - When it reaches TIMEOUT, fetch_err<=1 (sticky until reset).
  - The FSM stays in its state and keeps requesting.
- Undefined: no counter; fetch_err is tied to 0.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100.
  - Field bit-position localparams.
  - FSM state encoding typedef for the states REQ, HOLD and WAIT_DROP.
- One sub-module, pc_next_logic (combinational):
  - Inputs: PC, branch_taken, branch_target.
  - Outputs: next PC and pc_plus4.

Test Plan:
1. Reset release, imem_ack one cycle after req with rdata=32'h8C22_0004 -> imem_addr=0; then instr_valid=1, op=6'b100011, rs=1, rt=2, imm=16'h0004, pc_out=0, next imem_addr=4.
2. Fetch sequence 32'h0000_0000/0x00430820/0xAC22_0008/0x1022_FFFF -> op 000000, 000000, 101011, 000100 in order; pc_out 0, 4, 8, 12.
3. stall=1 for 5 cycles in HOLD -> imem_req=0, instr and pc_out unchanged. After release, req resumes at the same PC+4.
4. branch_taken with target 32'h0000_0043 in HOLD -> instr_valid=0 next cycle, imem_addr=32'h40.
5. Redirect during an outstanding fetch (ack delayed 3 cycles) -> imem_addr stays at the old value until ack, the data is dropped (instr_valid stays 0), then req at the target.
6. FETCH_TIMEOUT_EN with TIMEOUT=16 and ack withheld -> fetch_err=1 after 16 waiting cycles, stays set after a late ack, clears only on rst_n=0.
